// File: rtl/csr_timer_bank_pkg.sv
// rtl/csr_timer_bank_pkg.sv - shared register offsets and TCFG layout for csr_timer_bank
package csr_timer_bank_pkg;

    localparam logic [13:0] OFF_TCFG    = 14'd0;
    localparam logic [13:0] OFF_TVAL    = 14'd1;
    localparam logic [13:0] OFF_TICLR   = 14'd2;
    localparam int          REGS_PER_CH = 3;

    typedef struct packed {
        logic [29:0] init_val;
        logic        periodic;
        logic        en;
    } tcfg_t;

endpackage

// File: rtl/csr_timer_bank_timer_channel.sv
// rtl/csr_timer_bank_timer_channel.sv - one down-counting timer channel with sticky interrupt
module timer_channel
    import csr_timer_bank_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             cfg_we,
    input  logic             clr_we,
    input  logic [31:0]      wr_data,
    output logic [31:0]      tcfg,
    output logic [CNT_W-1:0] tval,
    output logic             irq
);

    logic [CNT_W-1:0] cfg_q, cfg_d;
    logic [CNT_W-1:0] tval_q, tval_d;
    logic             irq_q, irq_d;
    logic             expire;
    tcfg_t            cur_cfg;
    tcfg_t            wr_cfg;

    always_comb begin
        cur_cfg = tcfg_t'(32'(cfg_q));
        wr_cfg  = tcfg_t'(wr_data);
        cfg_d   = cfg_q;
        tval_d  = tval_q;
        irq_d   = irq_q;
        expire  = 1'b0;

        if (tick && cur_cfg.en) begin
            if (tval_q != '0) begin
                tval_d = tval_q - CNT_W'(1);
            end else begin
                expire = 1'b1;
                if (cur_cfg.periodic) begin
                    tval_d = CNT_W'({cur_cfg.init_val, 2'b00});
                end else begin
                    cfg_d[0] = 1'b0;
                end
            end
        end

        // A config write wins over the tick for TVAL/En; a coincident expiry still raises irq.
        if (cfg_we) begin
            cfg_d  = CNT_W'(wr_cfg);
            tval_d = wr_cfg.en ? CNT_W'({wr_cfg.init_val, 2'b00}) : tval_q;
        end

        if (clr_we && wr_data[0]) begin
            irq_d = 1'b0;
        end
        if (expire) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_q  <= '0;
            tval_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            cfg_q  <= cfg_d;
            tval_q <= tval_d;
            irq_q  <= irq_d;
        end
    end

    assign tcfg = 32'(cfg_q);
    assign tval = tval_q;
    assign irq  = irq_q;

endmodule

// File: rtl/csr_timer_bank.sv
// rtl/csr_timer_bank.sv - CSR-mapped bank of prescaled down-counting timers plus a stable counter
module csr_timer_bank
    import csr_timer_bank_pkg::*;
#(
    parameter int          NUM_TIMERS = 2,
    parameter int          CNT_W      = 32,
    parameter int          PRESCALE   = 1,
    parameter logic [13:0] BASE_ADDR  = 14'h41
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [13:0]           addr,
    input  logic                  we,
    input  logic [31:0]           mask,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    input  logic                  halt,
    output logic [NUM_TIMERS-1:0] timer_irq,
    output logic [63:0]           stable_cnt
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]         presc_q, presc_d;
    logic [63:0]           stable_cnt_q, stable_cnt_d;
    logic                  tick;
    logic [31:0]           merged;
    logic [NUM_TIMERS-1:0] sel_cfg, sel_val, sel_clr;
    logic [31:0]           ch_tcfg [NUM_TIMERS];
    logic [CNT_W-1:0]      ch_tval [NUM_TIMERS];

    always_comb begin
        tick    = !halt && (presc_q == PW'(PRESCALE - 1));
        presc_d = presc_q;
        if (!halt) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
        stable_cnt_d = stable_cnt_q + 64'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q      <= '0;
            stable_cnt_q <= '0;
        end else begin
            presc_q      <= presc_d;
            stable_cnt_q <= stable_cnt_d;
        end
    end

    assign stable_cnt = stable_cnt_q;

    for (genvar gi = 0; gi < NUM_TIMERS; gi++) begin : g_ch
        localparam logic [13:0] CH_BASE = BASE_ADDR + 14'(REGS_PER_CH * gi);

        assign sel_cfg[gi] = (addr == CH_BASE + OFF_TCFG);
        assign sel_val[gi] = (addr == CH_BASE + OFF_TVAL);
        assign sel_clr[gi] = (addr == CH_BASE + OFF_TICLR);

        timer_channel #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .tick    (tick),
            .cfg_we  (we && sel_cfg[gi]),
            .clr_we  (we && sel_clr[gi]),
            .wr_data (merged),
            .tcfg    (ch_tcfg[gi]),
            .tval    (ch_tval[gi]),
            .irq     (timer_irq[gi])
        );
    end

    // TICLR and unmapped addresses fall through to zero.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (sel_cfg[i]) rdata = ch_tcfg[i];
            if (sel_val[i]) rdata = 32'(ch_tval[i]);
        end
    end

    assign merged = (rdata & ~mask) | (wdata & mask);

endmodule

// File: tb/tb_csr_timer_bank.sv
// tb/tb_csr_timer_bank.sv - self-checking bench for csr_timer_bank
module tb_csr_timer_bank;

    localparam int          NT   = 2;
    localparam logic [13:0] BASE = 14'h41;

    logic        clk;
    logic        reset, we, halt;
    logic [13:0] addr;
    logic [31:0] mask, wdata, rdata;
    logic [NT-1:0] timer_irq;
    logic [63:0] stable_cnt;

    logic        reset4, we4, halt4;
    logic [13:0] addr4;
    logic [31:0] mask4, wdata4, rdata4;
    logic [0:0]  irq4;
    logic [63:0] stable4;

    int errors = 0;
    int checks = 0;

    csr_timer_bank #(.NUM_TIMERS(NT), .CNT_W(16), .PRESCALE(1), .BASE_ADDR(BASE)) u_dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .mask(mask), .wdata(wdata),
        .rdata(rdata), .halt(halt), .timer_irq(timer_irq), .stable_cnt(stable_cnt)
    );

    csr_timer_bank #(.NUM_TIMERS(1), .CNT_W(8), .PRESCALE(4), .BASE_ADDR(BASE)) u_dut4 (
        .clk(clk), .reset(reset4), .addr(addr4), .we(we4), .mask(mask4), .wdata(wdata4),
        .rdata(rdata4), .halt(halt4), .timer_irq(irq4), .stable_cnt(stable4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of u_dut (16-bit counters, every cycle is a tick unless halted)
    int unsigned     m_cfg  [NT];
    int unsigned     m_tval [NT];
    bit              m_irq  [NT];
    longint unsigned m_stable;

    function automatic int unsigned m_read(input logic [13:0] a);
        int off;
        off = int'(a) - int'(BASE);
        if (off < 0 || off >= 3 * NT) return 0;
        case (off % 3)
            0:       return m_cfg[off / 3];
            1:       return m_tval[off / 3];
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        int unsigned merged, old_tval;
        int off;
        bit expired;
        if (reset) begin
            for (int c = 0; c < NT; c++) begin
                m_cfg[c] = 0; m_tval[c] = 0; m_irq[c] = 0;
            end
            m_stable = 0;
            return;
        end
        merged = (m_read(addr) & ~mask) | (wdata & mask);
        off = int'(addr) - int'(BASE);
        for (int c = 0; c < NT; c++) begin
            expired  = 0;
            old_tval = m_tval[c];
            if (!halt && (m_cfg[c] & 1) != 0) begin
                if (m_tval[c] != 0) m_tval[c] = m_tval[c] - 1;
                else begin
                    expired = 1;
                    if ((m_cfg[c] & 2) != 0) m_tval[c] = m_cfg[c] & 32'hFFFC;
                    else m_cfg[c] = m_cfg[c] & ~32'd1;
                end
            end
            if (we && off == 3 * c) begin
                m_cfg[c]  = merged & 32'hFFFF;
                m_tval[c] = ((merged & 1) != 0) ? (merged & 32'hFFFC) : old_tval;
            end
            if (we && off == 3 * c + 2 && (merged & 1) != 0) m_irq[c] = 0;
            if (expired) m_irq[c] = 1;
        end
        m_stable = m_stable + 1;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic peek(input logic [13:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = rdata;
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] m, input logic [31:0] d);
        addr = a; mask = m; wdata = d; we = 1'b1;
        cyc();
        we = 1'b0;
    endtask

    initial begin
        logic [31:0] v, prev;
        logic [63:0] st;
        int n;

        for (int c = 0; c < NT; c++) begin
            m_cfg[c] = 0; m_tval[c] = 0; m_irq[c] = 0;
        end
        m_stable = 0;
        reset = 1; we = 0; halt = 0; addr = BASE; mask = '1; wdata = '0;
        reset4 = 1; we4 = 0; halt4 = 0; addr4 = BASE; mask4 = '1; wdata4 = '0;
        cyc(); cyc();
        chk("rst_irq", 64'(timer_irq), 0);
        chk("rst_stable", stable_cnt, 0);
        chk("rst_tcfg", 64'(rdata), 0);
        reset = 0; reset4 = 0;

        // One-shot on channel 0; upper bits beyond the 16-bit counter read 0
        wr(BASE, 32'hFFFF_FFFF, 32'hABCD_0011);
        peek(BASE, v);     chk("os_cfg", 64'(v), 64'h11);
        peek(BASE + 1, v); chk("os_load", 64'(v), 16);
        for (int k = 15; k >= 0; k--) begin
            cyc();
            chk("os_tval", 64'(rdata), 64'(k));
            chk("os_irq_low", 64'(timer_irq), 0);
        end
        cyc();
        chk("os_irq_set", 64'(timer_irq), 1);
        peek(BASE, v);     chk("os_en_clr", 64'(v), 64'h10);
        addr = BASE + 1; cyc(); cyc();
        chk("os_tval_hold", 64'(rdata), 0);
        wr(BASE + 2, 32'hFFFF_FFFF, 32'h1);
        chk("os_irq_clr", 64'(timer_irq), 0);
        peek(BASE + 2, v); chk("ticlr_reads0", 64'(v), 0);

        // Periodic on channel 1
        wr(BASE + 3, 32'hFFFF_FFFF, 32'h0B);
        peek(BASE + 4, v); chk("per_load", 64'(v), 8);
        for (int k = 7; k >= 0; k--) begin
            cyc();
            chk("per_tval", 64'(rdata), 64'(k));
        end
        cyc();
        chk("per_reload", 64'(rdata), 8);
        chk("per_irq", 64'(timer_irq), 64'b10);
        wr(BASE + 5, 32'hFFFF_FFFF, 32'h1);
        chk("per_irq_clr", 64'(timer_irq), 0);
        peek(BASE + 4, v); chk("per_tval7", 64'(v), 7);
        repeat (7) cyc();
        chk("race_pre", 64'(rdata), 0);
        wr(BASE + 5, 32'hFFFF_FFFF, 32'h1);
        chk("race_set_wins", 64'(timer_irq), 64'b10);
        peek(BASE + 4, v); chk("race_reload", 64'(v), 8);
        wr(BASE + 5, 32'hFFFF_FFFF, 32'h1);
        chk("race_later_clr", 64'(timer_irq), 0);

        // Masked write clears En only
        wr(BASE + 3, 32'h1, 32'h0);
        peek(BASE + 3, v); chk("mask_cfg", 64'(v), 64'h0A);
        peek(BASE + 4, prev);
        repeat (3) cyc();
        chk("mask_hold", 64'(rdata), 64'(prev));

        // Reset mid-count overrides a same-cycle write
        wr(BASE, 32'hFFFF_FFFF, 32'h11);
        addr = BASE + 1;
        repeat (11) cyc();
        chk("pre_reset_tval", 64'(rdata), 5);
        reset = 1;
        wr(BASE, 32'hFFFF_FFFF, 32'h11);
        chk("rst_mid_irq", 64'(timer_irq), 0);
        chk("rst_mid_stable", stable_cnt, 0);
        peek(BASE, v);     chk("rst_mid_tcfg", 64'(v), 0);
        peek(BASE + 1, v); chk("rst_mid_tval", 64'(v), 0);
        reset = 0;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            halt  = ($urandom_range(0, 7) == 0);
            we    = ($urandom_range(0, 5) == 0);
            addr  = 14'($urandom_range(32'h3F, 32'h48));
            mask  = ($urandom_range(0, 3) == 0) ? $urandom : 32'hFFFF_FFFF;
            wdata = $urandom & 32'hFFFF_003F;
            cyc();
            chk("rnd_irq", 64'(timer_irq), 64'({m_irq[1], m_irq[0]}));
            chk("rnd_stable", stable_cnt, m_stable);
            chk("rnd_rdata", 64'(rdata), 64'(m_read(addr)));
        end
        reset = 0; halt = 0; we = 0;

        // Prescale 4 and halt on the second instance
        addr4 = BASE; mask4 = '1; wdata4 = 32'h5; we4 = 1;
        cyc();
        we4 = 0; addr4 = BASE + 1;
        #1;
        chk("p4_load", 64'(rdata4), 4);
        prev = rdata4; n = 0;
        while (rdata4 == prev && n < 8) begin cyc(); n++; end
        chk("p4_first", 64'(rdata4), 3);
        prev = rdata4; n = 0;
        while (rdata4 == prev && n < 8) begin cyc(); n++; end
        chk("p4_period", 64'(n), 4);
        chk("p4_val", 64'(rdata4), 2);
        halt4 = 1; st = stable4;
        repeat (10) cyc();
        chk("halt_tval", 64'(rdata4), 2);
        chk("halt_stable", stable4, st + 64'd10);
        halt4 = 0;
        prev = rdata4; n = 0;
        while (rdata4 == prev && n < 8) begin cyc(); n++; end
        chk("halt_resume_period", 64'(n), 4);
        chk("halt_resume_val", 64'(rdata4), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
